pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 103 ++++++++++
 tb/tb_pc_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter generator with trap/eret/branch redirects and halt control
module pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int              INC          = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            fetch_ready,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            eret,
   input  logic            halt,
   input  logic            resume,
   output logic [XLEN-1:0] pc_out,
   output logic            pc_valid,
   output logic [XLEN-1:0] epc,
   output logic            flush,
   output logic            halted
);

   typedef enum logic [1:0] {
      S_RESET_WAIT = 2'd0,
      S_RUN        = 2'd1,
      S_HALT       = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC - 1));

   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] pc_nxt;
   logic [XLEN-1:0] epc_nxt;
   logic            flush_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_RESET_WAIT;
         pc_out <= RESET_VECTOR;
         epc    <= '0;
         flush  <= 1'b0;
      end else begin
         state  <= state_nxt;
         pc_out <= pc_nxt;
         epc    <= epc_nxt;
         flush  <= flush_nxt;
      end
   end

   // Redirect targets are aligned to INC; epc keeps the raw faulting PC.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_out;
      epc_nxt   = epc;
      flush_nxt = 1'b0;
      case (state)
         S_RESET_WAIT: begin
            state_nxt = S_RUN;
         end
         S_RUN: begin
            if (trap) begin
               pc_nxt    = TRAP_VECTOR & ALIGN_MASK;
               epc_nxt   = trap_pc;
               flush_nxt = 1'b1;
            end else begin
               if (eret) begin
                  pc_nxt    = epc & ALIGN_MASK;
                  flush_nxt = 1'b1;
               end else if (branch_taken) begin
                  pc_nxt    = branch_target & ALIGN_MASK;
                  flush_nxt = 1'b1;
               end else if (fetch_ready && !halt) begin
                  pc_nxt = pc_out + INC_W;
               end
               if (halt) begin
                  state_nxt = S_HALT;
               end
            end
         end
         S_HALT: begin
            if (trap) begin
               pc_nxt    = TRAP_VECTOR & ALIGN_MASK;
               epc_nxt   = trap_pc;
               flush_nxt = 1'b1;
               state_nxt = S_RUN;
            end else if (resume && !halt) begin
               state_nxt = S_RUN;
            end
         end
         default: begin
            state_nxt = S_RESET_WAIT;
         end
      endcase
   end

   assign pc_valid = (state == S_RUN);
   assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized scoreboard bench for pc_gen, 32-bit and 8-bit instances
module tb_pc_gen;

   localparam int INC    = 4;
   localparam int M_WAIT = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   localparam longint MODS [2] = '{64'h1_0000_0000, 64'h100};
   localparam longint TVEC [2] = '{64'h100, 64'h40};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        fetch_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        trap = 1'b0;
   logic [31:0] trap_pc = '0;
   logic        eret = 1'b0;
   logic        halt = 1'b0;
   logic        resume = 1'b0;

   logic [31:0] pc0, epc0;
   logic        valid0, flush0, halted0;
   logic [7:0]  pc1, epc1;
   logic        valid1, flush1, halted1;

   typedef struct {
      longint pc0;
      longint epc0;
      longint pc1;
      longint epc1;
      bit     valid;
      bit     flush;
      bit     halted;
   } exp_t;

   exp_t   sb[$];
   int     checks = 0;
   int     failures = 0;
   int     m_st = M_WAIT;
   longint m_pc [2];
   longint m_epc [2];

   pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .INC(INC)) dut32 (
      .clk(clk), .reset_n(reset_n), .fetch_ready(fetch_ready),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .trap(trap), .trap_pc(trap_pc), .eret(eret), .halt(halt), .resume(resume),
      .pc_out(pc0), .pc_valid(valid0), .epc(epc0), .flush(flush0), .halted(halted0)
   );

   pc_gen #(.XLEN(8), .RESET_VECTOR(8'h0), .TRAP_VECTOR(8'h40), .INC(INC)) dut8 (
      .clk(clk), .reset_n(reset_n), .fetch_ready(fetch_ready),
      .branch_taken(branch_taken), .branch_target(branch_target[7:0]),
      .trap(trap), .trap_pc(trap_pc[7:0]), .eret(eret), .halt(halt), .resume(resume),
      .pc_out(pc1), .pc_valid(valid1), .epc(epc1), .flush(flush1), .halted(halted1)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic longint align(input longint x);
      return (x / INC) * INC;
   endfunction

   task automatic model_reset();
      m_st = M_WAIT;
      for (int k = 0; k < 2; k++) begin
         m_pc[k]  = 0;
         m_epc[k] = 0;
      end
      sb.delete();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_pc32"},    longint'(pc0), 0);
      chk({tag, "_epc32"},   longint'(epc0), 0);
      chk({tag, "_pc8"},     longint'(pc1), 0);
      chk({tag, "_epc8"},    longint'(epc1), 0);
      chk({tag, "_valid"},   longint'(valid0), 0);
      chk({tag, "_flush"},   longint'(flush0), 0);
      chk({tag, "_halted"},  longint'(halted0), 0);
   endtask

   task automatic clear_inputs();
      fetch_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
      trap = 1'b0; trap_pc = '0; eret = 1'b0; halt = 1'b0; resume = 1'b0;
   endtask

   // Called at a negedge: drives one cycle of inputs and queues the state expected after the next posedge.
   task automatic step(input bit rdy, input bit br, input longint tgt, input bit tr,
                       input longint tpc, input bit er, input bit hl, input bit rs);
      exp_t e;
      int   n_st;
      bit   fl;
      fetch_ready = rdy; branch_taken = br; branch_target = 32'(tgt);
      trap = tr; trap_pc = 32'(tpc); eret = er; halt = hl; resume = rs;
      n_st = m_st;
      fl   = 1'b0;
      if (m_st == M_WAIT) begin
         n_st = M_RUN;
      end else if (tr) begin
         for (int k = 0; k < 2; k++) begin
            m_pc[k]  = align(TVEC[k]);
            m_epc[k] = tpc % MODS[k];
         end
         fl   = 1'b1;
         n_st = M_RUN;
      end else if (m_st == M_HALT) begin
         if (rs && !hl) n_st = M_RUN;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (er)                m_pc[k] = align(m_epc[k]);
            else if (br)           m_pc[k] = align(tgt % MODS[k]);
            else if (rdy && !hl)   m_pc[k] = (m_pc[k] + INC) % MODS[k];
         end
         fl = er || br;
         if (hl) n_st = M_HALT;
      end
      m_st     = n_st;
      e.pc0    = m_pc[0];
      e.epc0   = m_epc[0];
      e.pc1    = m_pc[1];
      e.epc1   = m_epc[1];
      e.valid  = (m_st == M_RUN);
      e.flush  = fl;
      e.halted = (m_st == M_HALT);
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      clear_inputs();
      model_reset();
      #1;
      check_reset_values("rst");
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(negedge clk);
      chk("wait_valid", longint'(valid0), 0);
   endtask

   task automatic reset_mid();
      @(posedge clk);
      #3;
      trap = 1'b1; trap_pc = 32'h77; branch_taken = 1'b1; branch_target = 32'h300;
      reset_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      model_reset();
      @(posedge clk);
      #2;
      clear_inputs();
      reset_n = 1'b1;
      @(negedge clk);
      chk("wait_valid_mid", longint'(valid0), 0);
   endtask

   always @(posedge clk) begin
      #1;
      if (reset_n && sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("pc_out32", longint'(pc0), e.pc0);
         chk("epc32",    longint'(epc0), e.epc0);
         chk("pc_out8",  longint'(pc1), e.pc1);
         chk("epc8",     longint'(epc1), e.epc1);
         chk("pc_valid", longint'(valid0), longint'(e.valid));
         chk("flush",    longint'(flush0), longint'(e.flush));
         chk("halted",   longint'(halted0), longint'(e.halted));
         chk("ctrl8",    longint'({valid1, flush1, halted1}),
                         longint'({e.valid, e.flush, e.halted}));
      end
   end

   initial begin
      do_reset();
      repeat (4) step(1, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 44, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 46, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 32'h200, 1, 32'h10, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 1, 32'h20, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 32'h80, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h55, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 32'h10, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      reset_mid();
      step(0, 0, 0, 1, 32'h99, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         longint tgt;
         tgt = ($urandom_range(0, 3) == 0) ? longint'(32'hFFFF_FF00 | $urandom_range(0, 255))
                                           : longint'($urandom);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, tgt,
              $urandom_range(0, 15) == 0, longint'($urandom),
              $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 2) == 0);
      end
      clear_inputs();
      repeat (2) @(negedge clk);
      chk("sb_drained", longint'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
